// File: rtl/vga_palette_encoder.sv
// Purpose : palette lookup of a pixel index into registered 8-bit R/G/B DAC drive, black when blanked.
// Latency : 2 clk from video_active/pixel_index to red/green/blue/out_active; write commit >= 1 clk after accept.
// Backpressure: single pending write slot; wr_ready low until the slot commits during blanking.
//
// Ports: clk, reset_n (async active-low); video_active, pixel_index -> red, green, blue, out_active;
//        wr_valid/wr_ready/wr_addr/wr_data palette write handshake, wr_done pulses on commit.
// Build option: define COLOR_EXPAND_EN for full-scale bit replication; default is legacy 32/32/64 scaling.

module vga_palette_encoder #(
    parameter int          INDEX_W = 2,
    parameter logic [7:0]  COLOR_0 = 8'h1C,
    parameter logic [7:0]  COLOR_1 = 8'hFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               video_active,
    input  logic [INDEX_W-1:0] pixel_index,
    input  logic               wr_valid,
    input  logic [INDEX_W-1:0] wr_addr,
    input  logic [7:0]         wr_data,
    output logic               wr_ready,
    output logic               wr_done,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               out_active
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [7:0]         pal_q [DEPTH];

    // The slot is pending exactly when wr_ready is low, so one flop serves both.
    logic               wr_rdy_q, wr_rdy_d;
    logic [INDEX_W-1:0] slot_addr_q, slot_addr_d;
    logic [7:0]         slot_data_q, slot_data_d;
    logic               wr_done_q, wr_done_d;
    logic               accept, commit;

    logic [7:0]         code_q;
    logic               act1_q;
    logic [7:0]         red_q, green_q, blue_q;
    logic               out_act_q;
    logic [7:0]         r_exp, g_exp, b_exp;

    // Accept needs an empty slot and commit needs a full one, so they can never share an edge.
    always_comb begin
        accept      = wr_valid && wr_rdy_q;
        commit      = !wr_rdy_q && !video_active;
        wr_rdy_d    = wr_rdy_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        wr_done_d   = commit;
        if (accept) begin
            wr_rdy_d    = 1'b0;
            slot_addr_d = wr_addr;
            slot_data_d = wr_data;
        end else if (commit) begin
            wr_rdy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_rdy_q    <= 1'b1;
            slot_addr_q <= '0;
            slot_data_q <= 8'h00;
            wr_done_q   <= 1'b0;
        end else begin
            wr_rdy_q    <= wr_rdy_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Palette storage; a commit and a stage-1 read of the same entry on one edge
    // returns the old contents because both sample pal_q before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal_q[i] <= (i == 0) ? COLOR_0 : ((i == 1) ? COLOR_1 : 8'h00);
            end
        end else if (commit) begin
            pal_q[slot_addr_q] <= slot_data_q;
        end
    end

    // Colour expansion of the RRRGGGBB code held in stage 1.
    always_comb begin
`ifdef COLOR_EXPAND_EN
        r_exp = {code_q[7:5], code_q[7:5], code_q[7:6]};
        g_exp = {code_q[4:2], code_q[4:2], code_q[4:3]};
        b_exp = {code_q[1:0], code_q[1:0], code_q[1:0], code_q[1:0]};
`else
        r_exp = {code_q[7:5], 5'b0_0000};
        g_exp = {code_q[4:2], 5'b0_0000};
        b_exp = {code_q[1:0], 6'b00_0000};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q    <= 8'h00;
            act1_q    <= 1'b0;
            red_q     <= 8'h00;
            green_q   <= 8'h00;
            blue_q    <= 8'h00;
            out_act_q <= 1'b0;
        end else begin
            code_q    <= pal_q[pixel_index];
            act1_q    <= video_active;
            red_q     <= act1_q ? r_exp : 8'h00;
            green_q   <= act1_q ? g_exp : 8'h00;
            blue_q    <= act1_q ? b_exp : 8'h00;
            out_act_q <= act1_q;
        end
    end

    assign wr_ready   = wr_rdy_q;
    assign wr_done    = wr_done_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign out_active = out_act_q;

endmodule

// File: tb/tb_vga_palette_encoder.sv
// Purpose : self-checking bench for vga_palette_encoder (INDEX_W=2 main instance, INDEX_W=4 second instance).
// Latency : streams table vectors one per clock and checks each two edges later.
// Backpressure: exercises pending-slot stalls during active video and back-to-back writes in blanking.

module tb_vga_palette_encoder;

`ifdef COLOR_EXPAND_EN
    localparam bit XP = 1'b1;
`else
    localparam bit XP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       video_active;
    logic [1:0] pixel_index;
    logic       wr_valid;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready, wr_done, out_active;
    logic [7:0] red, green, blue;

    logic       d4_active;
    logic [3:0] d4_index;
    logic       d4_wr_valid;
    logic [3:0] d4_wr_addr;
    logic [7:0] d4_wr_data;
    logic       d4_wr_ready, d4_wr_done, d4_out_active;
    logic [7:0] d4_red, d4_green, d4_blue;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    vga_palette_encoder #(.INDEX_W(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .video_active(video_active), .pixel_index(pixel_index),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_done(wr_done),
        .red(red), .green(green), .blue(blue), .out_active(out_active)
    );

    vga_palette_encoder #(.INDEX_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .video_active(d4_active), .pixel_index(d4_index),
        .wr_valid(d4_wr_valid), .wr_addr(d4_wr_addr), .wr_data(d4_wr_data),
        .wr_ready(d4_wr_ready), .wr_done(d4_wr_done),
        .red(d4_red), .green(d4_green), .blue(d4_blue), .out_active(d4_out_active)
    );

    typedef struct {
        logic       act;
        logic [1:0] idx;
        logic [7:0] rl, gl, bl;   // legacy scaling
        logic [7:0] rx, gx, bx;   // full-scale expansion
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one vector per clock; the output after edge k belongs to vector k-1.
    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            if (k < hi) begin
                video_active = vecs[k].act;
                pixel_index  = vecs[k].idx;
            end
            tick();
            if (k > lo) begin
                chk($sformatf("vec%0d red", k-1),   red,   XP ? vecs[k-1].rx : vecs[k-1].rl);
                chk($sformatf("vec%0d green", k-1), green, XP ? vecs[k-1].gx : vecs[k-1].gl);
                chk($sformatf("vec%0d blue", k-1),  blue,  XP ? vecs[k-1].bx : vecs[k-1].bl);
                chk($sformatf("vec%0d out_active", k-1), out_active, vecs[k-1].act);
            end
        end
    endtask

    initial begin
        // Defaults: entry0 = 1C, entry1 = FF, entries 2/3 = 00.
        vecs[0]  = '{1'b1, 2'd0, 8'h00, 8'hE0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[1]  = '{1'b1, 2'd1, 8'hE0, 8'hE0, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
        vecs[2]  = '{1'b0, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 2'd0, 8'h00, 8'hE0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        // After entry2 = E0.
        vecs[6]  = '{1'b1, 2'd2, 8'hE0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 2'd1, 8'hE0, 8'hE0, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
        // After entry3 = 03 and entry0 = 00.
        vecs[9]  = '{1'b1, 2'd3, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'hFF};
        vecs[10] = '{1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 2'd2, 8'hE0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        // After reset: defaults restored, discarded write to entry1 never landed.
        vecs[13] = '{1'b1, 2'd1, 8'hE0, 8'hE0, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
        vecs[14] = '{1'b1, 2'd0, 8'h00, 8'hE0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[15] = '{1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        reset_n = 1'b0; video_active = 1'b0; pixel_index = 2'd0;
        wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
        d4_active = 1'b0; d4_index = 4'd0; d4_wr_valid = 1'b0; d4_wr_addr = 4'd0; d4_wr_data = 8'h00;

        repeat (2) tick();
        reset_n = 1'b1;
        chk("reset wr_ready", wr_ready, 1'b1);
        chk("reset wr_done", wr_done, 1'b0);
        chk("reset rgb", {red, green, blue}, 24'h0);
        chk("reset out_active", out_active, 1'b0);

        run_vecs(0, 6);

        // Write entry2 during active video: held until blanking.
        video_active = 1'b1; pixel_index = 2'd0;
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'hE0;
        tick();
        wr_valid = 1'b0;
        chk("A accept wr_ready", wr_ready, 1'b0);
        chk("A accept wr_done", wr_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("A stall wr_done", wr_done, 1'b0);
            chk("A stall wr_ready", wr_ready, 1'b0);
        end
        video_active = 1'b0;
        tick();
        chk("A commit wr_done", wr_done, 1'b1);
        chk("A commit wr_ready", wr_ready, 1'b1);
        tick();
        chk("A after wr_done", wr_done, 1'b0);

        run_vecs(6, 9);

        // Back-to-back writes in blanking, second request held on the bus.
        video_active = 1'b0; n_done = 0;
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'h03;
        tick();
        chk("B accept1 wr_ready", wr_ready, 1'b0);
        wr_addr = 2'd0; wr_data = 8'h00;
        tick();
        n_done += int'(wr_done);
        chk("B commit1 wr_done", wr_done, 1'b1);
        chk("B commit1 wr_ready", wr_ready, 1'b1);
        tick();
        n_done += int'(wr_done);
        chk("B accept2 wr_ready", wr_ready, 1'b0);
        chk("B accept2 wr_done", wr_done, 1'b0);
        wr_valid = 1'b0;
        tick();
        n_done += int'(wr_done);
        chk("B commit2 wr_done", wr_done, 1'b1);
        tick();
        n_done += int'(wr_done);
        chk("B idle wr_ready", wr_ready, 1'b1);
        chk("B wr_done pulses", n_done, 2);

        run_vecs(9, 13);

        // Reset while a write to entry1 is pending during active video.
        video_active = 1'b1; pixel_index = 2'd1;
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h00;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("C pending wr_ready", wr_ready, 1'b0);
        chk("C pre-reset red", red, XP ? 8'hFF : 8'hE0);
        #2 reset_n = 1'b0;
        #1;
        chk("C async rgb", {red, green, blue}, 24'h0);
        chk("C async out_active", out_active, 1'b0);
        chk("C async wr_ready", wr_ready, 1'b1);
        tick();
        reset_n = 1'b1;
        chk("C release wr_ready", wr_ready, 1'b1);
        chk("C release wr_done", wr_done, 1'b0);

        run_vecs(13, 16);

        // Wide instance: top entry write, then read it and an untouched entry.
        d4_active = 1'b0;
        d4_wr_valid = 1'b1; d4_wr_addr = 4'd15; d4_wr_data = 8'h1C;
        tick();
        d4_wr_valid = 1'b0;
        tick();
        chk("D4 commit wr_done", d4_wr_done, 1'b1);
        d4_active = 1'b1; d4_index = 4'd15;
        tick();
        d4_index = 4'd7;
        tick();
        chk("D4 idx15 rgb", {d4_red, d4_green, d4_blue}, XP ? 24'h00FF00 : 24'h00E000);
        chk("D4 idx15 out_active", d4_out_active, 1'b1);
        tick();
        chk("D4 idx7 rgb", {d4_red, d4_green, d4_blue}, 24'h0);
        chk("D4 idx7 out_active", d4_out_active, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_palette_encoder.md
# vga_palette_encoder

Parametrised pixel-to-DAC colour stage for the DE2-115 VGA path. Maps an INDEX_W-bit pixel index through a programmable 2^INDEX_W-entry palette of 8-bit RRRGGGBB codes and drives registered 8-bit red/green/blue with forced black during blanking. Sits between the frame/pixel source and the VGA DAC pins. Palette writes are buffered and committed only during blanking, so active video never tears.

## Interface
- INDEX_W, 2, pixel index width; palette depth = 2^INDEX_W (1..8).
- COLOR_0, 8'h1C, reset value of palette entry 0.
- COLOR_1, 8'hFF, reset value of palette entry 1; entries ≥2 reset to 8'h00.

- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- video_active  in  1  high during visible pixels.
- pixel_index  in  INDEX_W  palette index for the current pixel.
- wr_valid  in  1  palette write request.
- wr_addr  in  INDEX_W  palette entry to write.
- wr_data  in  8  RRRGGGBB code.
- wr_ready  out  1  write slot free.
- wr_done  out  1  one-cycle pulse when a write commits to the palette.
- red / green / blue  out  8 each  DAC drive.
- out_active  out  1  video_active delayed to align with the colour outputs.

## Operation
- Reset (async, reset_n low): palette to defaults; pipeline registers, red/green/blue, out_active, wr_done to 0; pending slot empty; wr_ready = 1 on first cycle after release.
- Stage 1 (edge N): capture code = palette[pixel_index] and act1 = video_active.
- Stage 2 (edge N+1): if act1 then expand code to RGB, else RGB = 0; out_active = act1.
- Write handshake: accept when wr_valid && wr_ready; wr_addr/wr_data latch into single pending slot; wr_ready falls next cycle.
- Commit: on any edge where the slot is pending and video_active = 0, write palette[addr] = data, clear slot, pulse wr_done for that following cycle; wr_ready high again the cycle after commit.
- Pending held indefinitely while video_active = 1; no data is dropped, further wr_valid stalls (wr_ready = 0).
- Accept and commit never occur on the same edge; maximum write rate one per 2 cycles during blanking.
- Same-edge commit and stage-1 read of that entry: stage 1 sees the old value; new value visible from the next edge.
- Writes to every index (including 0, 1, and 2^INDEX_W−1) are legal.

## Timing
- Pixel latency: 2 clk from video_active/pixel_index to red/green/blue/out_active.
- Write latency: accept edge → earliest commit edge +1 (blanking) → wr_done high 1 cycle.
- Reset mid-frame or mid-write: outputs black immediately (async), pending write discarded, palette restored.
- All outputs registered; no combinational input→output path.

## Configuration
- COLOR_EXPAND_EN defined: bit replication to full scale — red = {R,R,R[2:1]}, green = {G,G,G[2:1]}, blue = {B,B,B,B}; code FF → FF/FF/FF.
- Not defined: legacy scaling — red = 32·R, green = 32·G, blue = 64·B; code FF → E0/E0/C0.
- Macro affects stage 2 only; latency and handshake unchanged.

## Test plan
- Reset release, video_active=1, index 0 then 1 → after 2 clk: expand build 00/FF/00 then FF/FF/FF; legacy 00/E0/00 then E0/E0/C0.
- video_active=0 with index 1 → RGB = 0, out_active = 0 two cycles later.
- During active video write addr 2 = E0 → wr_ready drops, no wr_done while active; first blank edge commits, wr_done pulses once; next active index 2 → red FF (legacy E0), green/blue 0.
- Back-to-back wr_valid in blanking (addr 3 = 03, addr 0 = 00) → accepts spaced 2 cycles, two wr_done pulses, index 3 → blue FF (legacy C0), index 0 → black.
- reset_n low while a write is pending and video active → RGB = 0 immediately, wr_ready = 1 after release, palette entry unchanged from default.
- INDEX_W=4 build: write addr 15 = 1C, read index 15 → green FF (legacy E0); unwritten index 7 → black.
